// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_bit.sv
// -----------------------------------------------------------------------------
// fa_bit
// Combinational one-bit full-adder cell, the only arithmetic element of the
// serial adder.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit      (a ^ b ^ ci)
//   co   : carry out    (majority of a, b, ci)
// -----------------------------------------------------------------------------
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa_bit

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder computing {c_out, sum} = a + b + c_in, one bit per clock,
// LSB first, through a single full-adder cell with a registered carry.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request strobe; accepted in IDLE or DONE, ignored in RUN
//   a, b, c_in : operands and carry-in, captured on an accepted start
//   busy       : high while bits are being processed (RUN)
//   done       : one-cycle pulse with sum/c_out valid (DONE)
//   sum, c_out : registered result, updated only on completion edges
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_sa;
  logic [WIDTH-1:0]  r_sb;
  logic [WIDTH-1:0]  r_ps;
  logic [WIDTH-1:0]  r_sum;
  logic [CW-1:0]     r_cnt;
  logic              r_cy;
  logic              r_c_out;

  logic              w_accept;
  logic              w_last;
  logic              w_s;
  logic              w_co;
  logic [WIDTH-1:0]  w_ps_shift;

  fa_bit u_fa (
    .a  (r_sa[0]),
    .b  (r_sb[0]),
    .ci (r_cy),
    .s  (w_s),
    .co (w_co)
  );

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST_BIT);

  // New sum bit enters at the MSB while the register shifts right; written
  // with shifts rather than a slice so WIDTH=1 stays legal.
  assign w_ps_shift = (r_ps >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  // NOTE: every signal assigned in this block gets a default on entry, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the operand and partial-sum shift registers are reset along with the
  // control state; an aborted run must leave no stale bits visible anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_ps    <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_cy  <= c_in;
      r_cnt <= '0;
      r_ps  <= '0;
    end else if (r_state == ST_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_cy  <= w_co;
      r_cnt <= r_cnt + CW'(1);
      r_ps  <= w_ps_shift;
      if (w_last) begin
        // Capture includes the bit being processed on this edge.
        r_sum   <= w_ps_shift;
        r_c_out <= w_co;
      end
    end
  end

  // Pure decodes of the state register: no input reaches an output
  // combinationally, and RUN/DONE are exclusive so busy and done never overlap.
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder: an 8-bit instance for the main scenarios
// and a 1-bit instance for the minimum width. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       c_in1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       c_out1;

  int n_pass;
  int n_total;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .c_in  (c_in1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .c_out (c_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for one edge; returns at the falling edge
  // just after the accepting rising edge, with start already dropped.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    a     = ta;
    b     = tb;
    c_in  = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done (bounded), and how many of them had busy.
  task automatic wait_done(output int cycles, output int busy_cnt, output bit overlap);
    cycles   = 0;
    busy_cnt = 0;
    overlap  = 1'b0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      @(negedge clk);
      cycles++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0; a  = '0; b  = '0; c_in  = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, sum, c_out} !== 11'h000)
      $display("FAIL reset_w8: busy=%b done=%b sum=%h c_out=%b, expected all 0", busy, done, sum, c_out);
    else n_pass++;
    n_total++;
    if ({busy1, done1, sum1, c_out1} !== 4'h0)
      $display("FAIL reset_w1: busy=%b done=%b sum=%b c_out=%b, expected all 0", busy1, done1, sum1, c_out1);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, bcnt;
    bit ovl;
    launch(8'h5A, 8'h33, 1'b0);
    wait_done(cyc, bcnt, ovl);
    n_total++;
    if (cyc !== 8) $display("FAIL basic_latency: done after %0d cycles, expected 8", cyc);
    else n_pass++;
    n_total++;
    if (bcnt !== 8) $display("FAIL basic_busy_cycles: busy %0d cycles, expected 8", bcnt);
    else n_pass++;
    n_total++;
    if (ovl !== 1'b0 || busy !== 1'b0) $display("FAIL basic_busy_done_overlap: overlap=%b busy=%b, expected 0", ovl, busy);
    else n_pass++;
    n_total++;
    if ({c_out, sum} !== 9'h08D) $display("FAIL basic_result: got c_out=%b sum=%h, expected c_out=0 sum=8d", c_out, sum);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_pulse: done=%b busy=%b a cycle later, expected 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_carries();
    logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h80};
    logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h80};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] ve [3] = '{9'h100, 9'h1FF, 9'h100};
    int cyc, bcnt;
    bit ovl;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], vc[i]);
      wait_done(cyc, bcnt, ovl);
      n_total++;
      if (cyc !== 8 || {c_out, sum} !== ve[i])
        $display("FAIL carry_vec%0d: cycles=%0d c_out=%b sum=%h, expected cycles=8 c_out=%b sum=%h",
                 i, cyc, c_out, sum, ve[i][8], ve[i][7:0]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, bcnt;
    bit ovl;
    // Previous result is 0x80+0x80 = {1, 0x00}.
    launch(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if ({c_out, sum} !== 9'h100 || busy !== 1'b1)
      $display("FAIL ignored_hold: busy=%b c_out=%b sum=%h during run, expected busy=1 c_out=1 sum=00", busy, c_out, sum);
    else n_pass++;
    wait_done(cyc, bcnt, ovl);
    n_total++;
    if (cyc !== 4) $display("FAIL ignored_schedule: done after %0d more cycles, expected 4", cyc);
    else n_pass++;
    n_total++;
    if ({c_out, sum} !== 9'h046) $display("FAIL ignored_result: c_out=%b sum=%h, expected c_out=0 sum=46", c_out, sum);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignored_idle: busy=%b done=%b, expected 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    bit ovl;
    launch(8'h01, 8'h02, 1'b0);
    wait_done(cyc, bcnt, ovl);
    n_total++;
    if (cyc !== 8 || {c_out, sum} !== 9'h003)
      $display("FAIL b2b_first: cycles=%0d c_out=%b sum=%h, expected cycles=8 c_out=0 sum=03", cyc, c_out, sum);
    else n_pass++;
    // Accept the next request in the DONE cycle.
    launch(8'h10, 8'h20, 1'b0);
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_restart: busy=%b done=%b, expected 1 0", busy, done);
    else n_pass++;
    wait_done(cyc, bcnt, ovl);
    n_total++;
    if (cyc !== 8 || bcnt !== 8 || {c_out, sum} !== 9'h030)
      $display("FAIL b2b_second: cycles=%0d busy=%0d c_out=%b sum=%h, expected 8 8 c_out=0 sum=30", cyc, bcnt, c_out, sum);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int cyc, bcnt, seen_done;
    bit ovl;
    launch(8'h77, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, sum, c_out} !== 11'h000)
      $display("FAIL midreset_outputs: busy=%b done=%b sum=%h c_out=%b, expected all 0", busy, done, sum, c_out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    n_total++;
    if (seen_done !== 0) $display("FAIL midreset_no_done: activity on %0d cycles after abort, expected 0", seen_done);
    else n_pass++;
    launch(8'h0F, 8'h01, 1'b1);
    wait_done(cyc, bcnt, ovl);
    n_total++;
    if (cyc !== 8 || {c_out, sum} !== 9'h011)
      $display("FAIL midreset_recover: cycles=%0d c_out=%b sum=%h, expected cycles=8 c_out=0 sum=11", cyc, c_out, sum);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_width1();
    a1 = 1'b1; b1 = 1'b1; c_in1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n_total++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) $display("FAIL w1_busy: busy=%b done=%b, expected 1 0", busy1, done1);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 1'b1 || c_out1 !== 1'b1)
      $display("FAIL w1_result: done=%b busy=%b sum=%b c_out=%b, expected 1 0 1 1", done1, busy1, sum1, c_out1);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done1 !== 1'b0 || sum1 !== 1'b1) $display("FAIL w1_after: done=%b sum=%b, expected done=0 sum held 1", done1, sum1);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_carries();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule : tb_serial_adder
